// File: rtl/contador_descendente_if.sv
// Control/status bundle for the loadable down-counter: the master drives the
// load/step controls, the slave (the counter) returns count and status strobes.
interface contador_descendente_if #(
  parameter int W = 5
);
  logic         enable;
  logic         load;
  logic [W-1:0] carga;
  logic         recarga;
  logic [W-1:0] count;
  logic         pulso;
  logic         activo;

  modport master (
    output enable, load, carga, recarga,
    input  count, pulso, activo
  );

  modport slave (
    input  enable, load, carga, recarga,
    output count, pulso, activo
  );
endinterface

// File: rtl/contador_descendente.sv
// Loadable down-counter/timer: counts a preset down to zero on enabled cycles,
// emits a one-cycle pulso at terminal count, then stops or reloads.
module contador_descendente #(
  parameter int MAXIMACUENTA = 28
) (
  input logic                    clk,
  input logic                    rst,
  contador_descendente_if.slave  bus
);
  localparam int W = $clog2(MAXIMACUENTA);
  localparam logic [W-1:0] MAXVAL = W'(MAXIMACUENTA - 1);
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] ZERO   = W'(0);

  typedef enum logic [0:0] {
    REPOSO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  estado_t      state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] preset_q, preset_d;
  logic         pulso_q, pulso_d;
  logic         activo_q, activo_d;
  logic [W-1:0] carga_sat_s;
  logic         evento_s;

  // Out-of-range start values saturate to the top of the count range.
  assign carga_sat_s = (bus.carga > MAXVAL) ? MAXVAL : bus.carga;

  // State, counter, preset and registered outputs; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REPOSO;
      count_q  <= ZERO;
      preset_q <= ZERO;
      pulso_q  <= 1'b0;
      activo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      pulso_q  <= pulso_d;
      activo_q <= activo_d;
    end
  end

  // Next state: load beats an enabled step; terminal count reloads or stops.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    evento_s = 1'b0;
    if (bus.load) begin
      count_d  = carga_sat_s;
      preset_d = carga_sat_s;
      state_d  = CONTANDO;
    end else begin
      case (state_q)
        CONTANDO: begin
          if (bus.enable) begin
            if (count_q != ZERO) begin
              count_d = count_q - ONE;
            end else begin
              evento_s = 1'b1;
              if (bus.recarga) begin
                count_d = preset_q;
                state_d = CONTANDO;
              end else begin
                count_d = ZERO;
                state_d = REPOSO;
              end
            end
          end else begin
            count_d = count_q;
          end
        end
        REPOSO: begin
          state_d = REPOSO;
        end
        default: begin
          state_d = REPOSO;
        end
      endcase
    end
  end

  // Output decode; activo follows the next state so it moves with the state edge.
  always_comb begin
    pulso_d  = evento_s;
    activo_d = (state_d == CONTANDO);
  end

  assign bus.count  = count_q;
  assign bus.pulso  = pulso_q;
  assign bus.activo = activo_q;
endmodule

// File: tb/tb_contador_descendente.sv
// Directed bench for contador_descendente: hand-computed expectations for
// reset, one-shot, auto-reload, enable gaps, load priority/clamp and edge cases.
module tb_contador_descendente;
  localparam int W = 5;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   pulses;

  contador_descendente_if #(.W(W)) bus ();

  contador_descendente #(.MAXIMACUENTA(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int c, input int p, input int a);
    chk({tag, ".count"},  32'(bus.count),  32'(c));
    chk({tag, ".pulso"},  32'(bus.pulso),  32'(p));
    chk({tag, ".activo"}, 32'(bus.activo), 32'(a));
  endtask

  task automatic do_load(input int v, input logic en, input logic rc);
    bus.load = 1'b1; bus.carga = W'(v); bus.enable = en; bus.recarga = rc;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.load = 1'b1; bus.carga = 5'd5; bus.recarga = 1'b0;

    // Reset held two cycles with a load request pending
    tick(); chk3("rst1", 0, 0, 0);
    tick(); chk3("rst2", 0, 0, 0);
    rst = 1'b0; bus.load = 1'b0;
    tick(); chk3("idle", 0, 0, 0);

    // One-shot from 3
    do_load(3, 1'b0, 1'b0); chk3("os_load", 3, 0, 1);
    bus.enable = 1'b1;
    tick(); chk3("os_2", 2, 0, 1);
    tick(); chk3("os_1", 1, 0, 1);
    tick(); chk3("os_0", 0, 0, 1);
    tick(); chk3("os_pulse", 0, 1, 0);
    tick(); chk3("os_after1", 0, 0, 0);
    tick(); chk3("os_after2", 0, 0, 0);

    // Auto-reload from 4: period 5
    do_load(4, 1'b0, 1'b1); chk3("ar_load", 4, 0, 1);
    bus.enable = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("ar_count", 32'(bus.count), 32'(4 - (i % 5)));
      chk("ar_pulso", 32'(bus.pulso), (i % 5 == 0) ? 32'd1 : 32'd0);
      if (bus.pulso) pulses++;
    end
    chk("ar_npulses", 32'(pulses), 32'd4);

    // Enable gaps: load 2, enable 1,0,1,0,1
    do_load(2, 1'b0, 1'b0); chk3("gap_load", 2, 0, 1);
    bus.enable = 1'b1; tick(); chk3("gap_e1", 1, 0, 1);
    bus.enable = 1'b0; tick(); chk3("gap_e0a", 1, 0, 1);
    bus.enable = 1'b1; tick(); chk3("gap_e2", 0, 0, 1);
    bus.enable = 1'b0; tick(); chk3("gap_e0b", 0, 0, 1);
    bus.enable = 1'b1; tick(); chk3("gap_e3", 0, 1, 0);

    // Load priority over enable, mid-count reload, clamp
    do_load(10, 1'b1, 1'b0); chk3("pri_load10", 10, 0, 1);
    tick(); chk3("pri_9", 9, 0, 1);
    tick(); chk3("pri_8", 8, 0, 1);
    do_load(6, 1'b1, 1'b0); chk3("pri_reload6", 6, 0, 1);
    tick(); chk3("pri_5", 5, 0, 1);
    do_load(31, 1'b1, 1'b0); chk3("clamp31", 27, 0, 1);
    tick(); chk3("clamp_26", 26, 0, 1);

    // Load 0, one-shot: pulse on first enabled cycle
    do_load(0, 1'b1, 1'b0); chk3("z_load", 0, 0, 1);
    tick(); chk3("z_pulse", 0, 1, 0);
    tick(); chk3("z_after", 0, 0, 0);

    // Auto-reload with preset 0: pulso high every enabled cycle
    do_load(0, 1'b1, 1'b1); chk3("z_ar_load", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk3("z_ar_pulse", 0, 1, 1);
    end
    bus.enable = 1'b0; tick(); chk3("z_ar_stall", 0, 0, 1);

    // Reset mid-run at count 2
    do_load(4, 1'b1, 1'b0); chk3("mr_load", 4, 0, 1);
    tick(); tick(); chk3("mr_2", 2, 0, 1);
    rst = 1'b1; tick(); chk3("mr_rst", 0, 0, 0);
    rst = 1'b0;
    tick(); chk3("mr_after1", 0, 0, 0);
    tick(); chk3("mr_after2", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/contador_descendente.md
# contador_descendente

Loadable down-counter/timer complementing the team's up-counter. It counts a programmed value down to zero on enabled cycles and emits a one-cycle `pulso` at terminal count. In one-shot mode it stops; in auto-reload mode it restarts from the stored value. It serves as a programmable timeout or period generator next to the free-running ascending counter.

## Interface

Parameters:
- `MAXIMACUENTA`, default 28: count range is 0..MAXIMACUENTA-1. Width `W = $clog2(MAXIMACUENTA)`, which is 5 at the default.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `enable`  in  1: count-step qualifier, active high.
- `load`  in  1: start strobe; captures `carga`.
- `carga`  in  W: start value, sampled only when `load`=1.
- `recarga`  in  1: 1 selects auto-reload; 0 selects one-shot. Sampled at terminal count.
- `count`  out  W: current counter value, registered.
- `pulso`  out  1: terminal-count strobe, registered, one cycle wide.
- `activo`  out  1: high while in CONTANDO, registered.

## Operation

- Internal registers: `count`, `preset` (W bits), and a state of either REPOSO or CONTANDO.
- Reset (sync, `rst`=1 at an edge) sets: `count`=0, `preset`=0, state=REPOSO, `pulso`=0, `activo`=0.
  - `rst` overrides `load` and `enable`.
  - Reset mid-count aborts the count with no pulse.
- Clamp: if `carga` > MAXIMACUENTA-1, both `count` and `preset` take MAXIMACUENTA-1.
- Priority per edge is `rst` > `load` > `enable` step.
- `load`=1 (any state):
  - `count` takes the clamped `carga`; `preset` takes the same value.
  - State goes to CONTANDO.
  - No decrement and no pulse that cycle, even with `enable`=1.
  - A load during CONTANDO restarts the count and cancels the pending terminal event.
- CONTANDO, `enable`=1, `load`=0:
  - `count` > 0: `count` decrements by 1 and `pulso` is 0.
  - `count` == 0: `pulso` is 1 for the next cycle. Then:
    - `recarga`=1: `count` takes `preset` and the state stays CONTANDO.
    - `recarga`=0: `count` stays 0 and the state goes to REPOSO.
- CONTANDO, `enable`=0: `count` holds and `pulso` is 0. A stalled terminal count waits for the next enabled cycle.
- REPOSO: `count` holds and `enable` is ignored. `pulso` is always 0 in REPOSO unless it is the cycle right after a one-shot terminal event.
- Load of 0: the next enabled cycle fires `pulso`.
- No underflow: `count` never wraps below 0.
- `activo` = (state == CONTANDO). Its registered value updates on the same edge as the state.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Load at edge k gives `count`=`carga` and `activo`=1 after edge k.
- Load of N, with `enable` held high from edge k+1:
  - `count` reads N-1 after edge k+1 and 0 after edge k+N.
  - `pulso`=1 after edge k+N+1 for exactly one cycle.
- Auto-reload with `enable` constant high: `pulso` period is `preset`+1 cycles. `count` cycles through preset..0.
- One-shot: `activo` drops on the same edge that raises `pulso`.
- `pulso` is never high on two consecutive cycles unless `preset`=0 in auto-reload mode. In that case `pulso` stays high every enabled cycle.
- `recarga` and `enable` are sampled only at edges. `carga` is sampled only on a `load` edge.

## Test plan

- Reset: drive `rst`=1 for 2 cycles while `load`=1, `carga`=5 -> `count`=0, `pulso`=0, `activo`=0, and the load is ignored.
- One-shot: load 3, `recarga`=0, `enable`=1 -> `count` runs 3,2,1,0. `pulso`=1 one cycle after `count` is first 0, with `activo`=0 in the same cycle. Further enables leave `count`=0 and `pulso`=0.
- Auto-reload: load 4, `recarga`=1, `enable`=1 for 20 cycles -> `pulso` every 5 cycles (4 pulses), `count` sequence 4,3,2,1,0,4,…
- Enable gaps: load 2, then toggle `enable` 1,0,1,0,1 -> `count` holds during `enable`=0, and `pulso` fires only after the third enabled cycle.
- Load priority and clamp:
  - load 10 with `enable`=1 in the same cycle -> `count`=10 with no decrement.
  - Reload 6 mid-count -> restarts from 6 with no pulse.
  - With MAXIMACUENTA=28, `carga`=31 -> `count`=27.
- Edge values and reset mid-run:
  - load 0 -> `pulso` on the first enabled cycle.
  - Auto-reload with `preset`=0 -> `pulso` constantly high while enabled.
  - `rst` at `count`=2 -> `count`=0, `activo`=0, and no pulse.
